// File: rtl/jsp_control_pkg.sv
// Shared control-word layout, increment-select codes and execute-stage state encoding.
package jsp_control_pkg;

  localparam int CTRL_W  = 16;
  localparam int INSTR_W = 8;

  // Control-word field positions
  localparam int ASSERT_LSB  = 0;
  localparam int ASSERT_MSB  = 3;
  localparam int LOAD_LSB    = 4;
  localparam int LOAD_MSB    = 7;
  localparam int INC_LSB     = 8;
  localparam int INC_MSB     = 9;
  localparam int ADDR_LSB    = 10;
  localparam int ADDR_MSB    = 12;
  localparam int BUS_REQ_BIT = 13;
  localparam int PCRA_BIT    = 14;
  localparam int BREAK_BIT   = 15;

  typedef enum logic [1:0] {
    INC_NONE = 2'd0,
    INC_SP   = 2'd1,
    INC_SI   = 2'd2,
    INC_DI   = 2'd3
  } inc_sel_e;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_BUS_WAIT = 2'd1,
    S_HALT     = 2'd2,
    S_FAULT    = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_stage3_onehot_decoder.sv
// Select code plus enable to one-hot strobe; code 0 means "nothing selected".
module onehot_decoder #(
  parameter int SEL_WIDTH = 4
) (
  input  logic [SEL_WIDTH-1:0]      sel,
  input  logic                      en,
  output logic [2**SEL_WIDTH-1:0]   onehot
);

  // Single bit set at the selected position; code 0 stays all-zero
  always_comb begin
    onehot = '0;
    if (en && (sel != '0)) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/pipeline_stage3.sv
// Execute stage: registers the control word, decodes strobes, runs the bus-request
// handshake with timeout and the break/halt handshake, and stalls upstream while waiting.
module pipeline_stage3
  import jsp_control_pkg::*;
#(
  parameter int SEL_WIDTH   = 4,
  parameter int BUS_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CTRL_W-1:0]         controls_in,
  input  logic [INSTR_W-1:0]        instruction_in,
  input  logic                      bus_grant,
  input  logic                      resume,
  output logic                      stall,
  output logic [2**SEL_WIDTH-1:0]   assert_en,
  output logic [2**SEL_WIDTH-1:0]   load_en,
  output logic                      inc_sp,
  output logic                      inc_si,
  output logic                      inc_di,
  output logic [2:0]                addr_select,
  output logic                      bus_request,
  output logic                      pcra_flip,
  output logic                      halted,
  output logic                      bus_fault,
  output logic [INSTR_W-1:0]        instruction_out
);

  // Counter is at least one bit wide so a disabled timeout still elaborates
  localparam int               CNT_W       = (BUS_TIMEOUT > 0) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(BUS_TIMEOUT);

  logic [CTRL_W-1:0]  ctrl_q;
  logic [INSTR_W-1:0] instr_q;
  state_e             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic               fire;
  logic               req_q, brk_q;
  logic [1:0]         inc_q;

  assign req_q = ctrl_q[BUS_REQ_BIT];
  assign brk_q = ctrl_q[BREAK_BIT];
  assign inc_q = ctrl_q[INC_MSB:INC_LSB];

  // The registered word executes in RUN unless it needs a bus not yet granted,
  // or in BUS_WAIT on the cycle the grant shows up (grant beats timeout)
  always_comb begin
    fire = ((state == S_RUN) && !(req_q && !bus_grant)) ||
           ((state == S_BUS_WAIT) && bus_grant);
  end

  assign stall = ~fire;

  // Control/instruction capture; held whenever this stage stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      instr_q <= '0;
    end else if (!stall) begin
      ctrl_q  <= controls_in;
      instr_q <= instruction_in;
    end
  end

  // State and wait counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic for bus wait, timeout and break handling
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    unique case (state)
      S_RUN: begin
        if (req_q && !bus_grant) begin
          state_nxt    = S_BUS_WAIT;
          wait_cnt_nxt = CNT_W'(1);
        end else if (brk_q) begin
          state_nxt = S_HALT;   // break word's strobes fire this cycle
        end
      end
      S_BUS_WAIT: begin
        if (bus_grant) begin
          state_nxt    = brk_q ? S_HALT : S_RUN;
          wait_cnt_nxt = '0;
        end else if ((BUS_TIMEOUT != 0) && (wait_cnt == TIMEOUT_VAL)) begin
          state_nxt = S_FAULT;
        end else if (wait_cnt != CNT_MAX) begin
          wait_cnt_nxt = wait_cnt + CNT_W'(1);
        end
      end
      S_HALT: begin
        if (resume) state_nxt = S_RUN;
      end
      S_FAULT: begin
        state_nxt = S_FAULT;    // sticky until reset
      end
      default: state_nxt = S_RUN;
    endcase
  end

  onehot_decoder #(.SEL_WIDTH(SEL_WIDTH)) u_assert_dec (
    .sel    (ctrl_q[ASSERT_LSB +: SEL_WIDTH]),
    .en     (fire),
    .onehot (assert_en)
  );

  onehot_decoder #(.SEL_WIDTH(SEL_WIDTH)) u_load_dec (
    .sel    (ctrl_q[LOAD_LSB +: SEL_WIDTH]),
    .en     (fire),
    .onehot (load_en)
  );

  // Gated strobes and status outputs
  always_comb begin
    inc_sp      = fire && (inc_q == INC_SP);
    inc_si      = fire && (inc_q == INC_SI);
    inc_di      = fire && (inc_q == INC_DI);
    pcra_flip   = fire && ctrl_q[PCRA_BIT];
    addr_select = ctrl_q[ADDR_MSB:ADDR_LSB];
    bus_request = req_q && ((state == S_RUN) || (state == S_BUS_WAIT));
    halted      = (state == S_HALT);
    bus_fault   = (state == S_FAULT);
  end

  assign instruction_out = instr_q;

endmodule

// File: tb/tb_pipeline_stage3.sv
// Directed bench for the execute stage: reset, decode, bus wait, timeout, break, combined.
module tb_pipeline_stage3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] controls_in;
  logic [7:0]  instruction_in;
  logic        bus_grant;
  logic        resume;
  logic        stall;
  logic [15:0] assert_en;
  logic [15:0] load_en;
  logic        inc_sp, inc_si, inc_di;
  logic [2:0]  addr_select;
  logic        bus_request;
  logic        pcra_flip;
  logic        halted;
  logic        bus_fault;
  logic [7:0]  instruction_out;

  int errors = 0;
  int checks = 0;

  pipeline_stage3 #(.SEL_WIDTH(4), .BUS_TIMEOUT(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .controls_in     (controls_in),
    .instruction_in  (instruction_in),
    .bus_grant       (bus_grant),
    .resume          (resume),
    .stall           (stall),
    .assert_en       (assert_en),
    .load_en         (load_en),
    .inc_sp          (inc_sp),
    .inc_si          (inc_si),
    .inc_di          (inc_di),
    .addr_select     (addr_select),
    .bus_request     (bus_request),
    .pcra_flip       (pcra_flip),
    .halted          (halted),
    .bus_fault       (bus_fault),
    .instruction_out (instruction_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then settle before the next one
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 reset_n = 1'b0;
    #3 reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    controls_in    = 16'h0000;
    instruction_in = 8'h00;
    bus_grant      = 1'b0;
    resume         = 1'b0;
    #2;
    chk("rst_assert", 32'(assert_en), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_instr", 32'(instruction_out), 32'h0);
    #10 reset_n = 1'b1;

    // Reset while waiting for the bus drops bus_request immediately
    controls_in = 16'h2012;
    step();                               // RUN, stalled on missing grant
    step();                               // BUS_WAIT
    chk("pre_rst_busreq", 32'(bus_request), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async_busreq", 32'(bus_request), 32'h0);
    chk("async_stall", 32'(stall), 32'h0);
    chk("async_assert", 32'(assert_en), 32'h0);
    #1 reset_n = 1'b1;
    controls_in = 16'h0000;
    step();
    chk("idle_assert", 32'(assert_en), 32'h0);
    chk("idle_load", 32'(load_en), 32'h0);
    chk("idle_stall", 32'(stall), 32'h0);

    // Plain decode
    controls_in = 16'h0253; instruction_in = 8'h5A;
    step();
    controls_in = 16'h0000; instruction_in = 8'h00;
    #1;
    chk("dec_assert", 32'(assert_en), 32'h0008);
    chk("dec_load", 32'(load_en), 32'h0020);
    chk("dec_inc_si", 32'(inc_si), 32'h1);
    chk("dec_inc_sp", 32'(inc_sp), 32'h0);
    chk("dec_addr", 32'(addr_select), 32'h0);
    chk("dec_stall", 32'(stall), 32'h0);
    chk("dec_instr", 32'(instruction_out), 32'h5A);

    // Remaining strobes and address select
    controls_in = 16'h5D00;               // pcra, addr 7, inc SP
    step();
    controls_in = 16'h0300;               // inc DI
    #1;
    chk("pcra_on", 32'(pcra_flip), 32'h1);
    chk("addr_sel7", 32'(addr_select), 32'h7);
    chk("inc_sp", 32'(inc_sp), 32'h1);
    step();
    controls_in = 16'h0000;
    #1;
    chk("inc_di", 32'(inc_di), 32'h1);
    chk("inc_di_sp", 32'(inc_sp), 32'h0);
    step();

    // Bus wait: grant arrives in the 4th cycle
    controls_in = 16'h2012;
    step();
    controls_in = 16'h0040;               // next word, held upstream
    #1;
    chk("bw1_stall", 32'(stall), 32'h1);
    chk("bw1_assert", 32'(assert_en), 32'h0);
    chk("bw1_busreq", 32'(bus_request), 32'h1);
    step();
    step();
    chk("bw3_stall", 32'(stall), 32'h1);
    chk("bw3_load", 32'(load_en), 32'h0);
    bus_grant = 1'b1;
    #1;
    chk("bw_grant_assert", 32'(assert_en), 32'h0004);
    chk("bw_grant_load", 32'(load_en), 32'h0002);
    chk("bw_grant_stall", 32'(stall), 32'h0);
    step();
    bus_grant = 1'b0;
    controls_in = 16'h0000;
    #1;
    chk("bw_next_load", 32'(load_en), 32'h0010);
    step();

    // Timeout with BUS_TIMEOUT=4
    controls_in = 16'h2001;
    step();                               // RUN, stalled
    controls_in = 16'h0000;
    step(); step(); step(); step();       // BUS_WAIT cnt 1..4
    chk("to_not_yet", 32'(bus_fault), 32'h0);
    step();
    chk("to_fault", 32'(bus_fault), 32'h1);
    chk("to_stall", 32'(stall), 32'h1);
    chk("to_busreq", 32'(bus_request), 32'h0);
    bus_grant = 1'b1;
    step(); step();
    chk("to_sticky", 32'(bus_fault), 32'h1);
    chk("to_sticky_assert", 32'(assert_en), 32'h0);
    bus_grant = 1'b0;
    do_reset();
    chk("to_cleared", 32'(bus_fault), 32'h0);

    // Break then resume
    controls_in = 16'h8011;
    step();
    controls_in = 16'h0022;
    #1;
    chk("brk_assert", 32'(assert_en), 32'h0002);
    chk("brk_load", 32'(load_en), 32'h0002);
    chk("brk_not_halted", 32'(halted), 32'h0);
    step();
    controls_in = 16'h0000;
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_stall", 32'(stall), 32'h1);
    chk("halt_assert", 32'(assert_en), 32'h0);
    step();
    chk("halt_hold", 32'(halted), 32'h1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    #1;
    chk("resume_assert", 32'(assert_en), 32'h0004);
    chk("resume_load", 32'(load_en), 32'h0004);
    chk("resume_halted", 32'(halted), 32'h0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    step();
    chk("resume_run_halted", 32'(halted), 32'h0);
    chk("resume_run_stall", 32'(stall), 32'h0);

    // Bus request plus break, grant after 2 wait cycles
    controls_in = 16'hA003;
    step();
    controls_in = 16'h0000;
    #1;
    chk("comb_stall", 32'(stall), 32'h1);
    chk("comb_pcra0", 32'(pcra_flip), 32'h0);
    step();
    step();
    bus_grant = 1'b1;
    #1;
    chk("comb_assert", 32'(assert_en), 32'h0008);
    chk("comb_pcra1", 32'(pcra_flip), 32'h0);
    step();
    bus_grant = 1'b0;
    #1;
    chk("comb_halted", 32'(halted), 32'h1);
    chk("comb_pcra2", 32'(pcra_flip), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
